seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Time-multiplexed driver for a common-segment, multi-digit 7-segment display. It consumes the 7-bit segment patterns produced by the per-digit BCD-to-segment encoders (score digits). It scans one digit at a time with a blanking gap between digits to suppress ghosting. A double-buffered load interface ensures a new score never tears mid-frame.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 500, cycles at the start of each slot with all outputs off (0 <= BLANK_CYCLES < REFRESH_DIV)
SEG_ACTIVE_LOW, 1, 1 = seg_out lit level is 0
DIG_ACTIVE_LOW, 1, 1 = dig_out enabled level is 0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
seg_in  in  7*NUM_DIGITS  packed patterns; digit k at [7k+6:7k]; bit0=a..bit6=g; 1 = segment lit
load  in  1  single-cycle strobe; captures seg_in into the pending buffer
seg_out  out  7  segment lines, polarity per SEG_ACTIVE_LOW
dig_out  out  NUM_DIGITS  digit enables, one-hot when driving, polarity per DIG_ACTIVE_LOW
digit_idx  out  3  index of the digit currently driven
frame_start  out  1  one-cycle pulse at the start of each digit-0 slot

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset state: pending and active buffers = 0. pending_valid = 0. Slot counter cnt = 0. digit index = 0. State = BLANK.
- Outputs during reset: seg_out = all-off level. dig_out = all-disabled level. digit_idx = 0. frame_start = 0.
- Slot counter: cnt counts 0..REFRESH_DIV-1 and wraps to 0. On wrap, digit index increments; NUM_DIGITS-1 wraps to 0.
- States: BLANK while cnt < BLANK_CYCLES, DRIVE otherwise. With BLANK_CYCLES = 0, BLANK is never entered after reset.
- Output latency: all outputs are registered with one cycle of latency. For a slot whose cnt=0 falls in cycle T:
  - outputs are off in cycles T+1..T+BLANK_CYCLES;
  - outputs are driven in cycles T+BLANK_CYCLES+1..T+REFRESH_DIV.
- DRIVE outputs: seg_out = active[idx] (inverted if SEG_ACTIVE_LOW). dig_out = one-hot(idx) (inverted if DIG_ACTIVE_LOW).
- digit_idx and frame_start follow the same one-cycle latency. frame_start is high in cycle T+1 of every digit-0 slot, including the first slot after reset release.
- Load: load=1 copies seg_in into pending and sets pending_valid. A later load before the swap overwrites pending; the last one wins.
- Swap: at cnt=0 of a digit-0 slot with pending_valid=1, active <= pending and pending_valid is cleared. The active buffer never changes at any other time.
- Load and swap in the same cycle: the swap uses the old pending contents. The new seg_in is captured into pending and pending_valid stays 1.
- reset mid-slot: aborts the slot immediately. Outputs go off on the next cycle and all buffered data is discarded.
- seg_in is sampled only on load cycles.

Optional Feature:
Macro SEG_LZ_BLANK_EN (leading-zero blanking).
- Defined: digit k (k >= 1) is forced off during its DRIVE phase when active[k] == 7'b0111111 ("0") and every digit above k is also "0" or blanked. Its dig_out stays disabled for that slot. Digit 0 is never blanked. Slot timing is unchanged.
- Undefined: every digit is driven exactly as stored.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1.
1. Reset held 5 cycles, then released with no load -> seg_out=7'h7F and dig_out=4'hF throughout reset. frame_start pulses in cycle 1 after release, then every 32 cycles. While driving, dig_out cycles E,D,B,7 with seg_out=7'h7F.
2. Load seg_in={7'h06,7'h5B,7'h4F,7'h66} mid-frame at digit 2 -> the current frame still shows zeros. From the next digit-0 slot, digit 0 shows ~7'h66=7'h19 and digit 3 shows ~7'h06=7'h79. Each digit is off for 2 cycles and driven for 6.
3. Load A at cnt=5 of digit 1, then load B at cnt=3 of digit 3, before the swap -> the next frame displays B only.
4. Load C on the exact cycle of a digit-0 slot with cnt=0 while pending holds A -> A is displayed this frame and C is displayed from the following frame.
5. Assert reset during cnt=4 of digit 2 -> outputs off the next cycle. After release, scanning restarts at digit 0 showing blank patterns.
6. With SEG_LZ_BLANK_EN, load digits {3:"0",2:"0",1:"7",0:"0"} -> digits 3 and 2 stay disabled for their whole slots. Digit 1 shows ~7'h07 and digit 0 shows ~7'h3F.

Source files
------------

// File: rtl/seven_seg_if.sv
// Bus between a score source and the 7-segment scanner: pattern load side plus display drive side.
interface seven_seg_if #(
    parameter int NUM_DIGITS = 4
);
    logic [7*NUM_DIGITS-1:0] seg_in;
    logic                    load;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   dig_out;
    logic [2:0]              digit_idx;
    logic                    frame_start;

    modport master (
        output seg_in, load,
        input  seg_out, dig_out, digit_idx, frame_start
    );

    modport slave (
        input  seg_in, load,
        output seg_out, dig_out, digit_idx, frame_start
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment scanner with per-slot blanking gap and tear-free double-buffered loads.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    seven_seg_if.slave bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0] SEG_ZERO = 7'h3F;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0][6:0]  pend_q, pend_d, act_q, act_d;
    logic                        pend_vld_q, pend_vld_d;
    logic [6:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       dig_q, dig_d;
    logic [2:0]                  didx_q, didx_d;
    logic                        fs_q, fs_d;
    logic                        frame_slot;
    logic [NUM_DIGITS-1:0]       lz_blank;

    // Slot timing and buffer management; the swap reads pending before any same-cycle load.
    always_comb begin
        frame_slot = (cnt_q == '0) && (idx_q == '0);
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        if (cnt_q == CNT_LAST)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (frame_slot && pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        if (bus.load) begin
            pend_d     = bus.seg_in;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        state_d = (cnt_d < BLANK_C) ? ST_BLANK : ST_DRIVE;
    end

`ifdef SEG_LZ_BLANK_EN
    logic lz_run;
    // A digit is blanked only while every digit above it is also a blanked zero.
    always_comb begin
        lz_blank = '0;
        lz_run   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_run      = lz_run && (act_d[k] == SEG_ZERO);
            lz_blank[k] = lz_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // act_d is used so a swap at cnt=0 is visible even when there is no blanking gap.
    always_comb begin
        seg_d  = SEG_OFF;
        dig_d  = DIG_OFF;
        didx_d = 3'(idx_q);
        fs_d   = frame_slot;
        if (state_q == ST_DRIVE && !lz_blank[idx_q]) begin
            seg_d = act_d[idx_q] ^ SEG_OFF;
            dig_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_q     <= '0;
            act_q      <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= SEG_OFF;
            dig_q      <= DIG_OFF;
            didx_q     <= '0;
            fs_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
            didx_q     <= didx_d;
            fs_q       <= fs_d;
        end
    end

    assign bus.seg_out     = seg_q;
    assign bus.dig_out     = dig_q;
    assign bus.digit_idx   = didx_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: vector table, directed corner sequences, random loads vs a slot-arithmetic model.
module tb_seven_seg_scanner;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seven_seg_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: position n counts clock edges since reset release.
    int                  n = 0;
    logic [ND-1:0][6:0]  m_pend = '0;
    logic [ND-1:0][6:0]  m_act = '0;
    bit                  m_pv = 1'b0;
    logic [6:0]          e_seg;
    logic [3:0]          e_dig;
    logic [2:0]          e_idx;
    logic                e_fs;

    typedef struct {
        bit          r;
        bit          ld;
        logic [27:0] d;
        logic [6:0]  seg;
        logic [3:0]  dig;
        logic [2:0]  idx;
        bit          fs;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_tick();
        int cnt, dg;
        bit blank, run;
        if (reset) begin
            n = 0; m_pend = '0; m_act = '0; m_pv = 1'b0;
            e_seg = 7'h7F; e_dig = 4'hF; e_idx = 3'd0; e_fs = 1'b0;
            return;
        end
        cnt = n % RD;
        dg  = (n / RD) % ND;
        if (cnt == 0 && dg == 0 && m_pv) begin
            m_act = m_pend;
            m_pv  = 1'b0;
        end
        blank = 1'b0;
        run   = 1'b1;
`ifdef SEG_LZ_BLANK_EN
        for (int k = ND - 1; k >= 1; k--) begin
            run = run && (m_act[k] == 7'h3F);
            if (k == dg && run) blank = 1'b1;
        end
`endif
        e_idx = 3'(dg);
        e_fs  = (cnt == 0 && dg == 0);
        if (cnt < BC || blank) begin
            e_seg = 7'h7F;
            e_dig = 4'hF;
        end else begin
            e_seg = ~m_act[dg];
            e_dig = ~(4'(1) << dg);
        end
        if (bus.load) begin
            m_pend = bus.seg_in;
            m_pv   = 1'b1;
        end
        n++;
    endtask

    task automatic cyc(input bit r, input bit ld, input logic [27:0] d);
        reset = r;
        bus.load = ld;
        bus.seg_in = d;
        @(posedge clk);
        model_tick();
        @(negedge clk);
        chk("seg_out", 32'(bus.seg_out), 32'(e_seg));
        chk("dig_out", 32'(bus.dig_out), 32'(e_dig));
        chk("digit_idx", 32'(bus.digit_idx), 32'(e_idx));
        chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
    endtask

    // Run idle cycles until position p has been executed.
    task automatic run_to(input int p);
        while (n <= p) cyc(1'b0, 1'b0, '0);
    endtask

    task automatic chk_out(input string name, input logic [6:0] seg, input logic [3:0] dig);
        chk({name, "_seg"}, 32'(bus.seg_out), 32'(seg));
        chk({name, "_dig"}, 32'(bus.dig_out), 32'(dig));
    endtask

    function automatic logic [27:0] rand_pat();
        logic [3:0][6:0] p;
        for (int k = 0; k < 4; k++)
            p[k] = ($urandom_range(0, 1) == 0) ? 7'h3F : 7'($urandom);
        return p;
    endfunction

    logic [27:0] a, b, c;
    logic [6:0]  ex;

    initial begin
        bus.load = 1'b0;
        bus.seg_in = '0;
        for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b0, 28'h0, 7'h7F, 4'hF, 3'd0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 28'h0, 7'h7F, 4'hF, 3'd0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 28'h0, 7'h7F, 4'hF, 3'd0, 1'b0};
        for (int i = 7; i < 13; i++) tbl[i] = '{1'b0, 1'b0, 28'h0, 7'h7F, 4'hE, 3'd0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 28'h0, 7'h7F, 4'hF, 3'd1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 28'h0, 7'h7F, 4'hF, 3'd1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 28'h0, 7'h7F, 4'hD, 3'd1, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].r, tbl[i].ld, tbl[i].d);
            chk("tbl_seg", 32'(bus.seg_out), 32'(tbl[i].seg));
            chk("tbl_dig", 32'(bus.dig_out), 32'(tbl[i].dig));
            chk("tbl_idx", 32'(bus.digit_idx), 32'(tbl[i].idx));
            chk("tbl_fs", 32'(bus.frame_start), 32'(tbl[i].fs));
        end

        // Load mid-frame while digit 2 is scanned; the frame in progress keeps zeros.
        run_to(16);
        cyc(1'b0, 1'b1, {7'h06, 7'h5B, 7'h4F, 7'h66});
        run_to(18); chk_out("s2_old", 7'h7F, 4'hB);
        run_to(34); chk_out("s2_d0", 7'h19, 4'hE);
        run_to(42); chk_out("s2_d1", 7'h30, 4'hD);
        run_to(58); chk_out("s2_d3", 7'h79, 4'h7);

        // Two loads before a swap: the later one wins.
        a = 28'($urandom);
        b = ~a;
        run_to(76); cyc(1'b0, 1'b1, a);
        run_to(90); cyc(1'b0, 1'b1, b);
        run_to(98); ex = ~b[6:0]; chk_out("s3_last", ex, 4'hE);

        // Load coinciding with the swap cycle.
        a = 28'($urandom);
        c = ~a;
        run_to(119); cyc(1'b0, 1'b1, a);
        run_to(127); cyc(1'b0, 1'b1, c);
        run_to(130); ex = ~a[6:0]; chk_out("s4_old", ex, 4'hE);
        run_to(162); ex = ~c[6:0]; chk_out("s4_new", ex, 4'hE);

        // Reset mid-slot discards both buffers.
        run_to(174); cyc(1'b0, 1'b1, 28'h1234567);
        run_to(179);
        cyc(1'b1, 1'b0, '0); chk_out("s5_rst", 7'h7F, 4'hF);
        chk("s5_idx", 32'(bus.digit_idx), 32'd0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, '0); chk("s5_fs", 32'(bus.frame_start), 32'd1);
        run_to(2);  chk_out("s5_d0", 7'h7F, 4'hE);
        run_to(10); chk_out("s5_d1", 7'h7F, 4'hD);
        run_to(34); chk_out("s5_nopend", 7'h7F, 4'hE);

        // Leading zeros above a nonzero digit.
        run_to(39); cyc(1'b0, 1'b1, {7'h3F, 7'h3F, 7'h07, 7'h3F});
        run_to(66); chk_out("s6_d0", 7'h40, 4'hE);
        run_to(74); chk_out("s6_d1", 7'h78, 4'hD);
`ifdef SEG_LZ_BLANK_EN
        run_to(82); chk_out("s6_d2", 7'h7F, 4'hF);
        run_to(90); chk_out("s6_d3", 7'h7F, 4'hF);
`else
        run_to(82); chk_out("s6_d2", 7'h40, 4'hB);
        run_to(90); chk_out("s6_d3", 7'h40, 4'h7);
`endif

        for (int i = 0; i < 900; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, rand_pat());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
